aer_uart_player: RTL and testbench
==================================

Name: aer_uart_player

Overview:
Synthesizable AER stimulus sequencer. It replays a preloaded spike list into the core's UART command port (rxd of fpga_core) as 2-byte AER event frames. It replaces bench-only UART tasks so that inference runs on hardware or in sim without per-bit bench timing. It adds a configurable address width, memory depth, loop mode, inter-frame gap and flow-control pause.

Parameters:
PRESCALE, 50, UART bit time = PRESCALE*8 clk cycles (same convention as the core's UART).
DEPTH, 2048, event memory entries.
IDX_W, 11, index width; must satisfy 2^IDX_W >= DEPTH.
EVT_W, 8, stored event width.
TSTEP_CODE, 8'hFF, stored value that denotes a time-step marker rather than a neuron spike.
GAP_CYCLES, 0, idle-high clk cycles inserted after each frame's second stop bit.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mem_we  in  1  event memory write strobe
mem_waddr  in  IDX_W  write index
mem_wdata  in  EVT_W  write data
num_events  in  IDX_W+1  list length; sampled on accepted start
loop_en  in  1  replay continuously; sampled on accepted start
start  in  1  single-cycle start request
stop  in  1  graceful stop request
pause  in  1  flow control; holds the next frame while high
txd  out  1  UART serial out, idle high
busy  out  1  playback active
done  out  1  1-cycle pulse at end of playback
events_sent  out  32  frames fully sent since last accepted start
loop_count  out  16  completed passes of the list in loop mode

Behaviour:
- Reset (async, any state): txd=1, busy=0, done=0, events_sent=0, loop_count=0, FSM=IDLE, index=0. Memory contents are not cleared.
- Memory: synchronous write. Synchronous read with 1-cycle latency. mem_we is ignored while busy=1.
- Frame format for event e:
  - Spike: byte0=8'h20, byte1=e.
  - e==TSTEP_CODE: byte0=8'h21, byte1=8'hFF.
  - byte0 layout = {4'b0010, 2'b00, addr[9:8]}, with addr[9:8]=2'b00 for a spike and 2'b01 for a marker.
- UART byte: start bit 0, 8 data bits LSB first, 1 stop bit. Each bit lasts exactly PRESCALE*8 cycles, so one byte = 80*PRESCALE cycles. byte1 starts in the cycle immediately after byte0's stop bit ends.
- FSM states:
  - IDLE: start && num_events!=0 -> FETCH; busy=1, index=0, events_sent=0, loop_count=0.
  - FETCH: waits while pause=1. Otherwise issues the memory read and then, on the next cycle, latches the event; -> SEND0.
  - SEND0 -> SEND1 -> GAP. GAP is skipped when GAP_CYCLES=0.
  - At frame end: events_sent+=1 and index+=1.
  - If index==num_events: with loop_en, index=0, loop_count+=1 (wraps at 2^16), -> FETCH; otherwise -> DONE.
  - If index!=num_events: -> FETCH.
  - DONE: done=1 for 1 cycle, busy=0, -> IDLE.
- start with num_events==0: no transmission; done pulses the cycle after start; busy stays 0.
- start while busy: ignored.
- stop while busy: latched. The current frame (both bytes and the gap) always completes, then -> DONE. A frame is never truncated. stop while IDLE: no effect.
- pause is sampled only in FETCH. Asserting pause mid-frame does not affect the frame in flight.
- Same-cycle start and stop in IDLE: start wins; the stop is discarded.
- num_events > DEPTH: clamped to DEPTH at the start sample.
- events_sent wraps at 2^32.
- txd is registered and glitch-free; it stays 1 in IDLE, FETCH and GAP.

Test Plan:
- PRESCALE=2, mem[0..2]={8'h05, 8'hFF, 8'h89}, num_events=3, start -> decoded bytes 20 05 21 FF 20 89. Each bit is 16 cycles; done pulses once; events_sent=3; busy spans the transmission.
- num_events=0, start -> txd stays 1; done pulses the cycle after start; busy never asserts.
- loop_en=1, num_events=2, run 5 frames then stop mid-byte1 of frame 5 -> frame 5 completes; loop_count=2; events_sent=5; done pulses once.
- pause held high for 1000 cycles between frames 1 and 2 -> txd stays high throughout; frame 2 follows on release; byte content unchanged.
- GAP_CYCLES=10 -> exactly 10 idle-high cycles between consecutive frames and none between byte0 and byte1.
- Reset asserted mid-start-bit -> txd=1 asynchronously, all outputs at reset values. A later start replays from index 0 with the memory contents preserved.

Source files
------------

// File: rtl/aer_uart_player.sv
// AER stimulus sequencer: replays a preloaded spike list as 2-byte UART event frames.
// Each frame is {byte0, byte1}; idle-high gap cycles may follow a frame.
module aer_uart_player #(
  parameter int unsigned     PRESCALE   = 50,
  parameter int unsigned     DEPTH      = 2048,
  parameter int unsigned     IDX_W      = 11,
  parameter int unsigned     EVT_W      = 8,
  parameter logic [EVT_W-1:0] TSTEP_CODE = EVT_W'(8'hFF),
  parameter int unsigned     GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_we,
  input  logic [IDX_W-1:0]  mem_waddr,
  input  logic [EVT_W-1:0]  mem_wdata,
  input  logic [IDX_W:0]    num_events,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic              txd,
  output logic              busy,
  output logic              done,
  output logic [31:0]       events_sent,
  output logic [15:0]       loop_count
);

  localparam int unsigned BIT_T    = PRESCALE * 8;
  localparam int unsigned TICK_W   = (BIT_T > 1) ? $clog2(BIT_T) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SEND0, S_SEND1, S_GAP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d, num_q, num_d;
  logic              loop_q, loop_d, stop_q, stop_d;
  logic [8:0]        shreg_q, shreg_d;
  logic [7:0]        byte1_q, byte1_d;
  logic [3:0]        bit_q, bit_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]       sent_q, sent_d;
  logic [15:0]       loops_q, loops_d;

  logic [EVT_W-1:0]  mem [DEPTH];
  logic [EVT_W-1:0]  rd_q;
  logic              rd_en_c;
  logic [IDX_W-1:0]  rd_addr_c;
  logic [CNT_W-1:0]  idx_inc_c;
  logic [7:0]        b0_c, b1_c;
  logic              frame_end_c, bit_end_c, stop_c;

  // Event memory; writes are frozen during playback so prefetched data stays coherent.
  always_ff @(posedge clk) begin
    if (mem_we && !busy_q) mem[mem_waddr] <= mem_wdata;
    if (rd_en_c) rd_q <= mem[rd_addr_c];
  end

  assign idx_inc_c = idx_q + CNT_W'(1);
  assign b0_c      = (rd_q == TSTEP_CODE) ? 8'h21 : 8'h20;
  assign b1_c      = (rd_q == TSTEP_CODE) ? 8'hFF : 8'(rd_q);
  assign bit_end_c = (tick_q == TICK_W'(BIT_T - 1));
  assign stop_c    = stop_q || stop;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    num_d       = num_q;
    loop_d      = loop_q;
    stop_d      = stop_q;
    shreg_d     = shreg_q;
    byte1_d     = byte1_q;
    bit_d       = bit_q;
    tick_d      = tick_q;
    gap_d       = gap_q;
    txd_d       = txd_q;
    sent_d      = sent_q;
    loops_d     = loops_q;
    rd_en_c     = 1'b0;
    rd_addr_c   = idx_q[IDX_W-1:0];
    frame_end_c = 1'b0;

    if (busy_q && stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (start) begin
          num_d   = (num_events > DEPTH_C) ? DEPTH_C : num_events;
          loop_d  = loop_en;
          stop_d  = 1'b0;
          idx_d   = '0;
          sent_d  = '0;
          loops_d = '0;
          state_d = (num_events != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        if (stop_c) begin
          state_d = S_DONE;
        end else if (!pause) begin
          rd_en_c = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        shreg_d = {1'b1, b0_c};
        byte1_d = b1_c;
        txd_d   = 1'b0;
        bit_d   = '0;
        tick_d  = '0;
        state_d = S_SEND0;
      end
      S_SEND0, S_SEND1: begin
        // Prefetch the next list entry while byte1 is on the wire.
        if (state_q == S_SEND1) begin
          rd_en_c   = 1'b1;
          rd_addr_c = (idx_inc_c == num_q) ? '0 : idx_inc_c[IDX_W-1:0];
        end
        if (!bit_end_c) begin
          tick_d = tick_q + TICK_W'(1);
        end else begin
          tick_d = '0;
          if (bit_q != 4'd9) begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shreg_q[0];
            shreg_d = {1'b1, shreg_q[8:1]};
          end else if (state_q == S_SEND0) begin
            shreg_d = {1'b1, byte1_q};
            txd_d   = 1'b0;
            bit_d   = '0;
            state_d = S_SEND1;
          end else begin
            txd_d = 1'b1;
            gap_d = '0;
            if (GAP_CYCLES == 0) frame_end_c = 1'b1;
            else state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) frame_end_c = 1'b1;
        else gap_d = gap_q + GAP_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame end doubles as the fetch decision so back-to-back frames keep the exact gap.
    if (frame_end_c) begin
      sent_d = sent_q + 32'd1;
      idx_d  = idx_inc_c;
      if (idx_inc_c == num_q && loop_q) begin
        idx_d   = '0;
        loops_d = loops_q + 16'd1;
      end
      if (stop_c || (idx_inc_c == num_q && !loop_q)) begin
        state_d = S_DONE;
      end else if (pause) begin
        state_d = S_FETCH;
      end else begin
        shreg_d = {1'b1, b0_c};
        byte1_d = b1_c;
        txd_d   = 1'b0;
        bit_d   = '0;
        tick_d  = '0;
        state_d = S_SEND0;
      end
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      shreg_q <= '1;
      byte1_q <= '0;
      bit_q   <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sent_q  <= '0;
      loops_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      byte1_q <= byte1_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sent_q  <= sent_d;
      loops_q <= loops_d;
    end
  end

  assign txd         = txd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign events_sent = sent_q;
  assign loop_count  = loops_q;

endmodule

// File: tb/tb_aer_uart_player.sv
// Scoreboard bench for aer_uart_player: expected UART bytes and inter-byte gaps are
// queued at stimulus time and compared as the txd decoder recovers each byte.
module tb_aer_uart_player;

  localparam int unsigned IDX_W = 4;
  localparam int          BIT_T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_waddr = '0;
  logic [7:0]  mem_wdata = '0;
  logic [4:0]  num_events = '0;
  logic        loop_en = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic        txd, busy, done;
  logic [31:0] events_sent;
  logic [15:0] loop_count;

  aer_uart_player #(
    .PRESCALE(2), .DEPTH(16), .IDX_W(IDX_W), .EVT_W(8),
    .TSTEP_CODE(8'hFF), .GAP_CYCLES(10)
  ) dut (
    .clk(clk), .rst(rst), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .num_events(num_events), .loop_en(loop_en),
    .start(start), .stop(stop), .pause(pause), .txd(txd), .busy(busy),
    .done(done), .events_sent(events_sent), .loop_count(loop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int gap; } exp_t;
  exp_t       sb[$];
  logic [7:0] model_mem [16];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, done_cnt = 0, mon_started = 0, prev_end = -1000;
  bit mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
  endtask

  // Push the two bytes of one frame; gap0 < 0 means the lead-in idle time is not checked.
  task automatic push_frame(input logic [7:0] e, input int gap0);
    exp_t x;
    x.b = (e == 8'hFF) ? 8'h21 : 8'h20; x.gap = gap0; sb.push_back(x);
    x.b = e;                            x.gap = 0;    sb.push_back(x);
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_started(input int target, input int max_cyc);
    for (int i = 0; i < max_cyc && mon_started < target; i++) @(negedge clk);
    check("byte_started", 32'(mon_started >= target), 32'd1);
  endtask

  task automatic pulse_start(input logic [4:0] n, input logic lp);
    @(negedge clk);
    num_events = n; loop_en = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // UART decoder: samples mid-bit and checks byte value and lead-in idle cycles.
  initial begin : monitor
    logic [7:0] d;
    int start_c;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        start_c = cyc;
        mon_started++;
        repeat (BIT_T/2 - 1) @(negedge clk);
        check("start_bit", 32'(txd), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_T) @(negedge clk);
          d[i] = txd;
        end
        repeat (BIT_T) @(negedge clk);
        check("stop_bit", 32'(txd), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("byte", 32'(d), 32'(e.b));
          if (e.gap >= 0) check("gap", 32'(start_c - prev_end), 32'(e.gap));
        end
        prev_end = start_c + 10 * BIT_T;
        repeat (BIT_T/2) @(negedge clk);
      end
    end
  end

  initial begin : stim
    int base, bad, d0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sent", events_sent, 32'd0);
    check("rst_loops", 32'(loop_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      model_mem[i] = (i == 0) ? 8'h05 : (i == 1) ? 8'hFF : (i == 2) ? 8'h89 : 8'(i * 16 + 3);
      @(negedge clk);
      mem_we = 1'b1; mem_waddr = 4'(i); mem_wdata = model_mem[i];
    end
    @(negedge clk); mem_we = 1'b0;

    // Basic three-frame list; a write attempted mid-playback must be ignored.
    d0 = done_cnt;
    push_frame(8'h05, -1); push_frame(8'hFF, 10); push_frame(8'h89, 10);
    pulse_start(5'd3, 1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    mem_we = 1'b1; mem_waddr = 4'd2; mem_wdata = 8'h33;
    @(negedge clk); mem_we = 1'b0;
    wait_done(3000);
    check("sent_basic", events_sent, 32'd3);
    check("sb_empty_basic", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("done_once_basic", 32'(done_cnt - d0), 32'd1);

    // Empty list: done the cycle after start, nothing on the wire.
    base = mon_started;
    @(negedge clk); num_events = 5'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("empty_done_low", 32'(done), 32'd0);
    check("empty_busy_low", 32'(busy), 32'd0);
    repeat (100) @(negedge clk);
    check("empty_no_tx", 32'(mon_started - base), 32'd0);

    // Loop mode, stop during byte1 of frame 5.
    d0 = done_cnt; base = mon_started;
    push_frame(8'h05, -1); push_frame(8'hFF, 10); push_frame(8'h05, 10);
    push_frame(8'hFF, 10); push_frame(8'h05, 10);
    pulse_start(5'd2, 1'b1);
    wait_started(base + 10, 6000);
    repeat (30) @(negedge clk);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done(2000);
    check("loop_count", 32'(loop_count), 32'd2);
    check("loop_sent", events_sent, 32'd5);
    check("sb_empty_loop", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("done_once_loop", 32'(done_cnt - d0), 32'd1);
    loop_en = 1'b0;

    // Pause between frames 1 and 2.
    base = mon_started;
    push_frame(8'h05, -1); push_frame(8'hFF, -1); push_frame(8'h89, 10);
    pulse_start(5'd3, 1'b0);
    wait_started(base + 2, 2000);
    repeat (20) @(negedge clk);
    pause = 1'b1;
    repeat (10 * BIT_T) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("pause_idle", 32'(bad), 32'd0);
    check("pause_no_byte", 32'(mon_started - base), 32'd2);
    pause = 1'b0;
    wait_done(3000);
    check("pause_sent", events_sent, 32'd3);
    check("sb_empty_pause", 32'(sb.size()), 32'd0);

    // Oversized length clamps to the memory depth.
    push_frame(model_mem[0], -1);
    for (int i = 1; i < 16; i++) push_frame(model_mem[i], 10);
    pulse_start(5'd20, 1'b0);
    wait_done(8000);
    check("clamp_sent", events_sent, 32'd16);
    check("sb_empty_clamp", 32'(sb.size()), 32'd0);

    // Asynchronous reset during the start bit, then a clean replay.
    mon_en = 1'b0;
    pulse_start(5'd3, 1'b0);
    bad = 1;
    for (int i = 0; i < 100 && bad != 0; i++) begin
      @(negedge clk);
      if (txd === 1'b0) bad = 0;
    end
    check("rst_test_tx_began", 32'(bad), 32'd0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_txd", 32'(txd), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sent", events_sent, 32'd0);
    check("arst_loops", 32'(loop_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    push_frame(8'h05, -1); push_frame(8'hFF, 10); push_frame(8'h89, 10);
    pulse_start(5'd3, 1'b0);
    wait_done(3000);
    check("replay_sent", events_sent, 32'd3);
    check("sb_empty_replay", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
